wb_region_mux: RTL and testbench
================================

Name: wb_region_mux

Overview:
- Parametrised Wishbone slave-side splitter for the user project wrapper. Generalises the fixed user/debug address split to NUM_SLAVES base/mask windows.
- Adds registered decode, per-transaction timeout with error completion, unmapped-address error completion, and sticky error status.
- Sits between the wrapper's Wishbone slave port and the user/debug register blocks.

Parameters:
NUM_SLAVES, 4, number of downstream windows
ADDR_W, 32, address width
DATA_W, 32, data width
SLV_BASE, {32'h30FFFFF8,32'h30020000,32'h30010000,32'h30000000}, packed NUM_SLAVES*ADDR_W window bases (index 0 in LSBs)
SLV_MASK, {32'hFFFFFFF8,32'hFFFF0000,32'hFFFF0000,32'hFFFF0000}, packed compare masks
TIMEOUT, 255, max cycles in ACTIVE before error completion (1..2^TMO_W-1)
TMO_W, 8, timeout counter width
ERR_DATA, 32'hDEADBEEF, read data returned on any error completion

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  synchronous reset, active-high
wbs_cyc_i/wbs_stb_i/wbs_we_i  in  1 each  master cycle, strobe, write enable
wbs_sel_i  in  DATA_W/8  byte select
wbs_adr_i  in  ADDR_W  address
wbs_dat_i  in  DATA_W  write data
wbs_ack_o  out  1  registered acknowledge
wbs_dat_o  out  DATA_W  registered read data
s_cyc_o/s_stb_o  out  NUM_SLAVES each  per-slave cycle/strobe, one-hot or zero
s_we_o, s_sel_o, s_adr_o, s_dat_o  out  1, DATA_W/8, ADDR_W, DATA_W  registered request fields, shared by all slaves
s_ack_i  in  NUM_SLAVES  per-slave acknowledge
s_dat_i  in  NUM_SLAVES*DATA_W  packed per-slave read data
err_pulse_o  out  1  one-cycle pulse on each error completion
err_adr_o  out  ADDR_W  address of the most recent error
err_cnt_o  out  16  saturating error count
err_clr_i  in  1  clears err_cnt_o and err_adr_o

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Applies mid-transaction: slave strobes drop next edge, no ack is issued.
- Hit for slave k: (wbs_adr_i & MASK[k]) == (BASE[k] & MASK[k]). On multiple hits the lowest index wins.
- FSM states: IDLE, ACTIVE, RESP.
- IDLE, cyc&stb, hit k:
  - Register index, adr/we/sel/dat into s_* fields.
  - Assert s_cyc_o[k] and s_stb_o[k]; clear timeout counter; go to ACTIVE.
- IDLE, cyc&stb, no hit:
  - Go to RESP with ack_o=1, dat_o=ERR_DATA, err_pulse_o=1.
  - wbs_ack_o is visible the cycle after the request (latency 1).
- ACTIVE:
  - s_ack_i[k]=1: drop s_cyc/s_stb; register wbs_dat_o=s_dat_i[k] (0 for writes); ack_o=1; go to RESP. Master ack latency is 2 cycles after the request for a zero-wait slave.
  - Otherwise, if wbs_cyc_i=0 (master abort): drop strobes; go to IDLE; no ack, no error.
  - Otherwise, counter==TIMEOUT-1: drop strobes; ack_o=1; dat_o=ERR_DATA; error event; go to RESP.
  - Otherwise counter++.
  - s_ack_i from non-selected slaves is ignored.
  - Slave ack in the same cycle as timeout expiry: ack wins, no error.
- RESP: wbs_ack_o high for exactly one cycle, then ack_o=0, dat_o=0, go to IDLE. No new request is evaluated in RESP, so the held strobe never launches a duplicate.
- Error event:
  - err_pulse_o=1 for one cycle.
  - err_adr_o <= request address.
  - err_cnt_o increments, saturating at 16'hFFFF.
  - err_clr_i in the same cycle as an error event: count becomes 1 and address is captured.
  - err_clr_i alone: both fields cleared.
- wbs_dat_o is 0 whenever wbs_ack_o=0.

Test Plan:
1. Read 0x30010004, slave1 acks its first strobed cycle with 0x12345678 -> s_stb_o=4'b0010 one cycle after request; wbs_ack_o two cycles after request, single cycle, dat 0x12345678; err_cnt_o=0.
2. Write 0x30FFFFFC with dat 0xA5A5A5A5, sel 4'hF -> s_stb_o=4'b1000, s_adr_o=0x30FFFFFC, s_dat_o=0xA5A5A5A5, s_we_o=1; single ack.
3. Read unmapped 0x40000000 -> no s_stb_o; ack one cycle after request with 0xDEADBEEF; err_pulse_o for 1 cycle; err_adr_o=0x40000000; err_cnt_o=1.
4. Read 0x30000000 with slave0 never acking, TIMEOUT=255 -> s_stb_o[0] high for 255 cycles; ack with 0xDEADBEEF; err_cnt_o increments.
   - Variant: slave acks in the expiry cycle -> normal data, no error.
5. Master drops cyc after 3 cycles in ACTIVE, then wb_rst_i pulsed during a second ACTIVE -> strobes drop, no ack, no error; all outputs 0 after reset.
6. Preload err_cnt_o=16'hFFFF and force another error -> count stays 16'hFFFF. Then err_clr_i together with an error -> err_cnt_o=1.

Source files
------------

// File: rtl/wb_region_mux.sv
// Wishbone slave-side splitter: routes each request to one of NUM_SLAVES base/mask windows
// with registered decode, per-transaction timeout, unmapped-address errors and sticky error status.
module wb_region_mux #(
    parameter int                           NUM_SLAVES = 4,
    parameter int                           ADDR_W     = 32,
    parameter int                           DATA_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE   = {32'h30FFFFF8, 32'h30020000, 32'h30010000, 32'h30000000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK   = {32'hFFFFFFF8, 32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000},
    parameter int                           TIMEOUT    = 255,
    parameter int                           TMO_W      = 8,
    parameter logic [DATA_W-1:0]            ERR_DATA   = 32'hDEADBEEF
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_i,
    input  logic                         wbs_cyc_i,
    input  logic                         wbs_stb_i,
    input  logic                         wbs_we_i,
    input  logic [DATA_W/8-1:0]          wbs_sel_i,
    input  logic [ADDR_W-1:0]            wbs_adr_i,
    input  logic [DATA_W-1:0]            wbs_dat_i,
    output logic                         wbs_ack_o,
    output logic [DATA_W-1:0]            wbs_dat_o,
    output logic [NUM_SLAVES-1:0]        s_cyc_o,
    output logic [NUM_SLAVES-1:0]        s_stb_o,
    output logic                         s_we_o,
    output logic [DATA_W/8-1:0]          s_sel_o,
    output logic [ADDR_W-1:0]            s_adr_o,
    output logic [DATA_W-1:0]            s_dat_o,
    input  logic [NUM_SLAVES-1:0]        s_ack_i,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_dat_i,
    output logic                         err_pulse_o,
    output logic [ADDR_W-1:0]            err_adr_o,
    output logic [15:0]                  err_cnt_o,
    input  logic                         err_clr_i
);

    localparam int               IDX_W    = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int               SEL_W    = DATA_W / 8;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t                  state_q,     state_d;
    logic [IDX_W-1:0]        idx_q,       idx_d;
    logic [TMO_W-1:0]        tmo_q,       tmo_d;
    logic [NUM_SLAVES-1:0]   stb_q,       stb_d;
    logic                    we_q,        we_d;
    logic [SEL_W-1:0]        sel_q,       sel_d;
    logic [ADDR_W-1:0]       adr_q,       adr_d;
    logic [DATA_W-1:0]       wdat_q,      wdat_d;
    logic                    ack_q,       ack_d;
    logic [DATA_W-1:0]       rdat_q,      rdat_d;
    logic                    err_pulse_q, err_pulse_d;
    logic [ADDR_W-1:0]       err_adr_q,   err_adr_d;
    logic [15:0]             err_cnt_q,   err_cnt_d;

    logic [NUM_SLAVES-1:0]   match_s;
    logic                    hit_s;
    logic [IDX_W-1:0]        hit_idx_s;
    logic                    sel_ack_s;
    logic [DATA_W-1:0]       sel_dat_s;
    logic                    err_ev_s;
    logic [ADDR_W-1:0]       err_ev_adr_s;

    // Window decode of the incoming address; descending scan so the lowest index wins.
    always_comb begin
        match_s   = '0;
        hit_idx_s = '0;
        for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
            match_s[k] = ((wbs_adr_i & SLV_MASK[k*ADDR_W +: ADDR_W]) ==
                          (SLV_BASE[k*ADDR_W +: ADDR_W] & SLV_MASK[k*ADDR_W +: ADDR_W]));
            hit_idx_s  = match_s[k] ? IDX_W'(k) : hit_idx_s;
        end
        hit_s = |match_s;
    end

    // Response mux for the slave latched at launch; other slaves' acks never reach the FSM.
    always_comb begin
        sel_ack_s = 1'b0;
        sel_dat_s = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            sel_ack_s = (idx_q == IDX_W'(k)) ? s_ack_i[k] : sel_ack_s;
            sel_dat_s = (idx_q == IDX_W'(k)) ? s_dat_i[k*DATA_W +: DATA_W] : sel_dat_s;
        end
    end

    // Transaction FSM: launch, wait for slave ack / abort / timeout, one-cycle response.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        tmo_d        = tmo_q;
        stb_d        = stb_q;
        we_d         = we_q;
        sel_d        = sel_q;
        adr_d        = adr_q;
        wdat_d       = wdat_q;
        ack_d        = 1'b0;
        rdat_d       = '0;
        err_ev_s     = 1'b0;
        err_ev_adr_s = adr_q;
        case (state_q)
            ST_IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    if (hit_s) begin
                        idx_d   = hit_idx_s;
                        we_d    = wbs_we_i;
                        sel_d   = wbs_sel_i;
                        adr_d   = wbs_adr_i;
                        wdat_d  = wbs_dat_i;
                        stb_d   = NUM_SLAVES'(1) << hit_idx_s;
                        tmo_d   = '0;
                        state_d = ST_ACTIVE;
                    end else begin
                        ack_d        = 1'b1;
                        rdat_d       = ERR_DATA;
                        err_ev_s     = 1'b1;
                        err_ev_adr_s = wbs_adr_i;
                        state_d      = ST_RESP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                // Slave ack is tested first so it beats a simultaneous timeout expiry.
                if (sel_ack_s) begin
                    stb_d   = '0;
                    ack_d   = 1'b1;
                    rdat_d  = we_q ? '0 : sel_dat_s;
                    state_d = ST_RESP;
                end else if (!wbs_cyc_i) begin
                    stb_d   = '0;
                    state_d = ST_IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    stb_d    = '0;
                    ack_d    = 1'b1;
                    rdat_d   = ERR_DATA;
                    err_ev_s = 1'b1;
                    state_d  = ST_RESP;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                stb_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sticky error status; a clear coinciding with an error still records that error.
    always_comb begin
        err_pulse_d = err_ev_s;
        err_adr_d   = err_adr_q;
        err_cnt_d   = err_cnt_q;
        if (err_ev_s) begin
            err_adr_d = err_ev_adr_s;
            if (err_clr_i) begin
                err_cnt_d = 16'd1;
            end else if (err_cnt_q == 16'hFFFF) begin
                err_cnt_d = 16'hFFFF;
            end else begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
        end else if (err_clr_i) begin
            err_adr_d = '0;
            err_cnt_d = 16'd0;
        end else begin
            err_adr_d = err_adr_q;
            err_cnt_d = err_cnt_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            tmo_q       <= '0;
            stb_q       <= '0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            wdat_q      <= '0;
            ack_q       <= 1'b0;
            rdat_q      <= '0;
            err_pulse_q <= 1'b0;
            err_adr_q   <= '0;
            err_cnt_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tmo_q       <= tmo_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            wdat_q      <= wdat_d;
            ack_q       <= ack_d;
            rdat_q      <= rdat_d;
            err_pulse_q <= err_pulse_d;
            err_adr_q   <= err_adr_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = rdat_q;
    assign s_cyc_o     = stb_q;
    assign s_stb_o     = stb_q;
    assign s_we_o      = we_q;
    assign s_sel_o     = sel_q;
    assign s_adr_o     = adr_q;
    assign s_dat_o     = wdat_q;
    assign err_pulse_o = err_pulse_q;
    assign err_adr_o   = err_adr_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_wb_region_mux.sv
// Self-checking bench for wb_region_mux: directed plan scenarios plus randomized traffic
// checked against a transaction-level model of decode, latency and error status.
module tb_wb_region_mux;

    localparam int          TIMEOUT  = 255;
    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

    logic         clk = 1'b0;
    logic         rst;
    logic         wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]   wbs_sel_i;
    logic [31:0]  wbs_adr_i, wbs_dat_i;
    logic         wbs_ack_o;
    logic [31:0]  wbs_dat_o;
    logic [3:0]   s_cyc_o, s_stb_o;
    logic         s_we_o;
    logic [3:0]   s_sel_o;
    logic [31:0]  s_adr_o, s_dat_o;
    logic [3:0]   s_ack_i;
    logic [127:0] s_dat_i;
    logic         err_pulse_o;
    logic [31:0]  err_adr_o;
    logic [15:0]  err_cnt_o;
    logic         err_clr_i;

    int          vec  = 0;
    int          miss = 0;
    logic [15:0] m_cnt = 16'd0;
    logic [31:0] m_adr = 32'd0;
    bit          clr_req  = 1'b0;
    bit          hold_req = 1'b0;

    wb_region_mux dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
        .err_pulse_o(err_pulse_o), .err_adr_o(err_adr_o), .err_cnt_o(err_cnt_o),
        .err_clr_i(err_clr_i)
    );

    always #5 clk = ~clk;

    // Window rule straight from the address map: first window whose masked compare matches.
    function automatic int model_hit(input logic [31:0] a);
        logic [31:0] b [4];
        logic [31:0] m [4];
        b = '{32'h30000000, 32'h30010000, 32'h30020000, 32'h30FFFFF8};
        m = '{32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000, 32'hFFFFFFF8};
        for (int k = 0; k < 4; k++) begin
            if ((a & m[k]) == (b[k] & m[k])) return k;
        end
        return -1;
    endfunction

    // One master transaction; the bench plays the slaves, acking after wait_cyc strobed cycles.
    task automatic run_txn(input logic [31:0] addr, input logic w, input logic [31:0] wd,
                           input logic [3:0] sl, input int wait_cyc, input logic [31:0] rd);
        int          idx, stb_cnt, cyc_cnt, exp_stb;
        bit          done, exp_err;
        logic [31:0] exp_dat;
        logic [3:0]  exp_oh;
        idx     = model_hit(addr);
        exp_err = (idx < 0) || (wait_cyc >= TIMEOUT);
        exp_dat = exp_err ? ERR_DATA : (w ? 32'h0 : rd);
        exp_stb = (idx < 0) ? 0 : ((wait_cyc + 1 < TIMEOUT) ? wait_cyc + 1 : TIMEOUT);
        exp_oh  = (idx < 0) ? 4'b0000 : (4'b0001 << idx);
        if (clr_req) begin m_cnt = 16'd0; m_adr = 32'd0; end
        if (exp_err) begin
            m_cnt = (m_cnt == 16'hFFFF) ? 16'hFFFF : m_cnt + 16'd1;
            m_adr = addr;
        end
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = w; wbs_sel_i = sl;
        wbs_adr_i = addr; wbs_dat_i = wd; err_clr_i = clr_req;
        s_ack_i   = 4'($urandom) & ~exp_oh;
        done = 1'b0; stb_cnt = 0; cyc_cnt = 0;
        while (!done && cyc_cnt < 400) begin
            @(negedge clk);
            cyc_cnt++;
            err_clr_i = 1'b0;
            s_ack_i   = 4'($urandom) & ~exp_oh;
            s_dat_i   = {$urandom, $urandom, $urandom, $urandom};
            if (wbs_ack_o === 1'b1) begin
                done = 1'b1;
                vec++; if (wbs_dat_o !== exp_dat) begin miss++; $display("FAIL rdata adr=%h got=%h exp=%h", addr, wbs_dat_o, exp_dat); end
                vec++; if (err_pulse_o !== exp_err) begin miss++; $display("FAIL err_pulse adr=%h got=%b exp=%b", addr, err_pulse_o, exp_err); end
                vec++; if (stb_cnt != exp_stb) begin miss++; $display("FAIL stb_cycles adr=%h got=%0d exp=%0d", addr, stb_cnt, exp_stb); end
                vec++; if (cyc_cnt != exp_stb + 1) begin miss++; $display("FAIL ack_latency adr=%h got=%0d exp=%0d", addr, cyc_cnt, exp_stb + 1); end
                vec++; if ({s_cyc_o, s_stb_o} !== 8'h00) begin miss++; $display("FAIL stb_at_ack got=%b/%b exp=0", s_cyc_o, s_stb_o); end
                vec++; if (err_cnt_o !== m_cnt || err_adr_o !== m_adr) begin miss++; $display("FAIL err_status got=%h/%h exp=%h/%h", err_cnt_o, err_adr_o, m_cnt, m_adr); end
                if (!hold_req) begin wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; end
            end else begin
                vec++; if (wbs_dat_o !== 32'h0 || err_pulse_o !== 1'b0) begin miss++; $display("FAIL quiet_out got dat=%h pulse=%b exp 0/0", wbs_dat_o, err_pulse_o); end
                if (s_stb_o !== 4'b0000) begin
                    stb_cnt++;
                    vec++; if (s_stb_o !== exp_oh || s_cyc_o !== exp_oh) begin miss++; $display("FAIL onehot adr=%h got=%b/%b exp=%b", addr, s_cyc_o, s_stb_o, exp_oh); end
                    if (stb_cnt == 1) begin
                        vec++;
                        if ({s_we_o, s_sel_o, s_adr_o, s_dat_o} !== {w, sl, addr, wd}) begin
                            miss++; $display("FAIL req_fields got=%b %h %h %h exp=%b %h %h %h", s_we_o, s_sel_o, s_adr_o, s_dat_o, w, sl, addr, wd);
                        end
                    end
                    if (idx >= 0 && stb_cnt > wait_cyc) begin
                        s_ack_i = s_ack_i | exp_oh;
                        s_dat_i[idx*32 +: 32] = rd;
                    end
                end
            end
        end
        if (!done) begin
            miss++; $display("FAIL no_ack adr=%h got none within 400 cycles exp ack", addr);
            wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        end
        if (hold_req) begin
            @(negedge clk);
            vec++; if (wbs_ack_o !== 1'b0 || s_stb_o !== 4'b0000) begin miss++; $display("FAIL held_strobe got ack=%b stb=%b exp 0/0", wbs_ack_o, s_stb_o); end
            wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        end
        @(negedge clk);
        s_ack_i = 4'b0000;
        vec++;
        if ({wbs_ack_o, wbs_dat_o, s_stb_o, err_pulse_o} !== 38'h0) begin
            miss++; $display("FAIL post_resp got ack=%b dat=%h stb=%b pulse=%b exp all 0", wbs_ack_o, wbs_dat_o, s_stb_o, err_pulse_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0; wbs_sel_i = 4'h0;
        wbs_adr_i = 32'h0; wbs_dat_i = 32'h0; s_ack_i = 4'h0; s_dat_i = 128'h0; err_clr_i = 1'b0;
        repeat (3) @(negedge clk);
        vec++;
        if ({wbs_ack_o, wbs_dat_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o, err_pulse_o, err_adr_o, err_cnt_o} !== 192'h0) begin
            miss++; $display("FAIL reset_outputs got ack=%b dat=%h stb=%b cnt=%h adr=%h exp all 0", wbs_ack_o, wbs_dat_o, s_stb_o, err_cnt_o, err_adr_o);
        end
        rst = 1'b0;
        m_cnt = 16'd0; m_adr = 32'd0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_txn(32'h30010004, 1'b0, 32'h0, 4'hF, 0, 32'h12345678);
        run_txn(32'h30FFFFFC, 1'b1, 32'hA5A5A5A5, 4'hF, 0, 32'h0BADF00D);
        run_txn(32'h40000000, 1'b0, 32'h0, 4'hF, 0, 32'h0);
        run_txn(32'h30020008, 1'b0, 32'h0, 4'h3, 3, 32'hCAFEF00D);
    endtask

    task automatic test_timeout();
        run_txn(32'h30000000, 1'b0, 32'h0, 4'hF, TIMEOUT, 32'h11111111);
        run_txn(32'h30000000, 1'b0, 32'h0, 4'hF, TIMEOUT - 1, 32'h22222222);
    endtask

    task automatic test_abort_reset();
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h30020010; s_ack_i = 4'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vec++; if (s_stb_o !== 4'b0100) begin miss++; $display("FAIL abort_stb cyc=%0d got=%b exp=0100", i, s_stb_o); end
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vec++;
            if ({wbs_ack_o, s_stb_o, err_pulse_o} !== 6'h0 || err_cnt_o !== m_cnt) begin
                miss++; $display("FAIL abort_quiet got ack=%b stb=%b pulse=%b cnt=%h exp 0/0/0/%h", wbs_ack_o, s_stb_o, err_pulse_o, err_cnt_o, m_cnt);
            end
        end
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = 32'h30000040;
        @(negedge clk);
        vec++; if (s_stb_o !== 4'b0001) begin miss++; $display("FAIL pre_reset_stb got=%b exp=0001", s_stb_o); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        m_cnt = 16'd0; m_adr = 32'd0;
        vec++;
        if ({wbs_ack_o, wbs_dat_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o, err_pulse_o, err_adr_o, err_cnt_o} !== 192'h0) begin
            miss++; $display("FAIL midtxn_reset got ack=%b stb=%b adr=%h cnt=%h exp all 0", wbs_ack_o, s_stb_o, s_adr_o, err_cnt_o);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vec++; if (wbs_ack_o !== 1'b0 || s_stb_o !== 4'b0000) begin miss++; $display("FAIL post_reset_quiet got ack=%b stb=%b exp 0/0", wbs_ack_o, s_stb_o); end
        end
    endtask

    task automatic test_err_status();
        force dut.err_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.err_cnt_q;
        m_cnt = 16'hFFFF;
        @(negedge clk);
        vec++; if (err_cnt_o !== 16'hFFFF) begin miss++; $display("FAIL preload got=%h exp=ffff", err_cnt_o); end
        run_txn(32'h40000000, 1'b0, 32'h0, 4'hF, 0, 32'h0);
        clr_req = 1'b1;
        run_txn(32'h50000010, 1'b0, 32'h0, 4'hF, 0, 32'h0);
        clr_req = 1'b0;
        err_clr_i = 1'b1;
        @(negedge clk);
        err_clr_i = 1'b0;
        m_cnt = 16'd0; m_adr = 32'd0;
        vec++; if (err_cnt_o !== 16'd0 || err_adr_o !== 32'd0) begin miss++; $display("FAIL clr_alone got=%h/%h exp 0/0", err_cnt_o, err_adr_o); end
    endtask

    task automatic test_back_to_back();
        hold_req = 1'b1;
        run_txn(32'h30010100, 1'b0, 32'h0, 4'hF, 0, 32'h600DCAFE);
        run_txn(32'h70000000, 1'b0, 32'h0, 4'hF, 0, 32'h0);
        hold_req = 1'b0;
        run_txn(32'h30FFFFF8, 1'b1, 32'h13572468, 4'h5, 1, 32'h0);
        run_txn(32'h30000008, 1'b0, 32'h0, 4'hF, 0, 32'h89ABCDEF);
    endtask

    task automatic test_random();
        logic [31:0] bases [4];
        logic [31:0] masks [4];
        logic [31:0] a;
        int          r, wt;
        bases = '{32'h30000000, 32'h30010000, 32'h30020000, 32'h30FFFFF8};
        masks = '{32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000, 32'hFFFFFFF8};
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 4);
            a = (r < 4) ? (bases[r] | ($urandom & ~masks[r])) : $urandom;
            wt = ($urandom_range(0, 9) == 0) ? 300 : $urandom_range(0, 6);
            clr_req  = ($urandom_range(0, 7) == 0);
            hold_req = ($urandom_range(0, 3) == 0);
            run_txn(a, 1'($urandom), $urandom, 4'($urandom), wt, $urandom);
        end
        clr_req = 1'b0; hold_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_timeout();
        test_abort_reset();
        test_err_status();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
